// File: rtl/top_ctrl_pkg.sv
// Shared types for the attention-pass sequencer: state encoding, enable bundle
// and the state-to-enable decode.
package top_ctrl_pkg;

  localparam int NUM_WEIGHT_DEF = 4;
  localparam int NUM_TOKENS_DEF = 21;
  localparam int CNT_W_DEF      = 8;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LOAD_W  = 4'd1,
    ST_GEN_K   = 4'd2,
    ST_STORE_K = 4'd3,
    ST_GEN_Q   = 4'd4,
    ST_LOAD_Q  = 4'd5,
    ST_SOFTMAX = 4'd6,
    ST_QK      = 4'd7,
    ST_MAC     = 4'd8,
    ST_STORE_S = 4'd9,
    ST_DONE    = 4'd10
  } state_t;

  typedef struct packed {
    logic cs_qkv;
    logic cimeb_qkv;
    logic cs_qk;
    logic k_mode_qk;
    logic q_mode_qk;
    logic en_softmax;
    logic cme_softmax;
    logic weight_dma;
    logic loadk_dma;
    logic loadq_dma;
    logic loadscore_dma;
  } enables_t;

  function automatic enables_t decode_state(input state_t st);
    enables_t e;
    e = '0;
    case (st)
      ST_LOAD_W: begin
        e.weight_dma = 1'b1;
        e.cs_qkv     = 1'b1;
      end
      ST_GEN_K, ST_GEN_Q: begin
        e.cs_qkv    = 1'b1;
        e.cimeb_qkv = 1'b1;
      end
      ST_STORE_K: begin
        e.cs_qk     = 1'b1;
        e.k_mode_qk = 1'b1;
        e.loadk_dma = 1'b1;
      end
      ST_LOAD_Q: begin
        e.cs_qk     = 1'b1;
        e.loadq_dma = 1'b1;
      end
      ST_SOFTMAX: begin
        e.en_softmax  = 1'b1;
        e.cme_softmax = 1'b1;
      end
      ST_QK: begin
        e.cs_qk     = 1'b1;
        e.q_mode_qk = 1'b1;
      end
      ST_MAC: begin
        e.cs_qkv     = 1'b1;
        e.cimeb_qkv  = 1'b1;
        e.en_softmax = 1'b1;
      end
      ST_STORE_S: begin
        e.loadscore_dma = 1'b1;
        e.en_softmax    = 1'b1;
      end
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/top_controller.sv
// Attention-pass sequencer: weight load, K generation/store, then a per-token
// loop of Q load, softmax (skipped on the first pass), QK, MAC and score store.
module top_controller
  import top_ctrl_pkg::*;
#(
  parameter int NUM_WEIGHT = NUM_WEIGHT_DEF,
  parameter int NUM_TOKENS = NUM_TOKENS_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic done_weight_dma,
  input  logic done_cimeb_qkv,
  input  logic done_k_mode_dma,
  input  logic done_loadq_dma,
  input  logic done_q_mode_qk,
  input  logic done_cme_softmax,
  input  logic down_loadscore_dma,
  input  logic done_loadk_dma,
  output logic enable_cs_qkv,
  output logic enable_cimeb_qkv,
  output logic enable_cs_qk,
  output logic enable_k_mode_qk,
  output logic enable_q_mode_qk,
  output logic enable_en_softmax,
  output logic enable_cme_softmax,
  output logic enable_weight_dma,
  output logic enable_loadk_dma,
  output logic enable_loadq_dma,
  output logic enable_loadscore_dma
);

  localparam logic [CNT_W-1:0] W_LAST = CNT_W'(NUM_WEIGHT - 1);
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(NUM_TOKENS - 1);
  localparam logic [CNT_W-1:0] C_MAX  = '1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wcnt, wcnt_nxt;
  logic [CNT_W-1:0] tcnt, tcnt_nxt;
  logic             first, first_nxt;
  enables_t         en;

  // The K-transfer done is not part of the sequence; kept only to close the port.
  logic unused_loadk;
  assign unused_loadk = done_loadk_dma;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      wcnt  <= '0;
      tcnt  <= '0;
      first <= 1'b1;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      tcnt  <= tcnt_nxt;
      first <= first_nxt;
    end
  end

  // Each state reacts only to its own unit's done; everything else is ignored.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    tcnt_nxt  = tcnt;
    first_nxt = first;
    case (state)
      ST_IDLE: state_nxt = ST_LOAD_W;
      ST_LOAD_W: begin
        if (done_weight_dma) begin
          if (wcnt == W_LAST) begin
            wcnt_nxt  = '0;
            state_nxt = ST_GEN_K;
          end else if (wcnt != C_MAX) begin
            wcnt_nxt = wcnt + 1'b1;
          end
        end
      end
      ST_GEN_K:   if (done_cimeb_qkv)   state_nxt = ST_STORE_K;
      ST_STORE_K: if (done_k_mode_dma)  state_nxt = ST_GEN_Q;
      ST_GEN_Q:   if (done_cimeb_qkv)   state_nxt = ST_LOAD_Q;
      ST_LOAD_Q:  if (done_loadq_dma)   state_nxt = first ? ST_QK : ST_SOFTMAX;
      ST_SOFTMAX: if (done_cme_softmax) state_nxt = ST_QK;
      ST_QK:      if (done_q_mode_qk)   state_nxt = ST_MAC;
      ST_MAC:     if (done_cimeb_qkv)   state_nxt = ST_STORE_S;
      ST_STORE_S: begin
        if (down_loadscore_dma) begin
          first_nxt = 1'b0;
          if (tcnt != C_MAX) tcnt_nxt = tcnt + 1'b1;
          state_nxt = (tcnt == T_LAST) ? ST_DONE : ST_LOAD_Q;
        end
      end
      ST_DONE: state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Moore decode straight off the state register, so reset clears it at once.
  always_comb en = decode_state(state);

  assign enable_cs_qkv        = en.cs_qkv;
  assign enable_cimeb_qkv     = en.cimeb_qkv;
  assign enable_cs_qk         = en.cs_qk;
  assign enable_k_mode_qk     = en.k_mode_qk;
  assign enable_q_mode_qk     = en.q_mode_qk;
  assign enable_en_softmax    = en.en_softmax;
  assign enable_cme_softmax   = en.cme_softmax;
  assign enable_weight_dma    = en.weight_dma;
  assign enable_loadk_dma     = en.loadk_dma;
  assign enable_loadq_dma     = en.loadq_dma;
  assign enable_loadscore_dma = en.loadscore_dma;

endmodule

// File: tb/tb_top_controller.sv
// Scoreboard bench for top_controller: directed done pulses push the expected
// enable pattern; a negedge monitor pops and compares.
module tb_top_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic d_weight = 0, d_cimeb = 0, d_kmode = 0, d_loadq = 0;
  logic d_qmode = 0, d_cme = 0, d_score = 0, d_loadk = 0;
  logic o_cs_qkv, o_cimeb, o_cs_qk, o_kmode, o_qmode, o_en_sm, o_cme;
  logic o_weight, o_loadk, o_loadq, o_score;

  top_controller dut (
    .clk(clk), .rst(rst),
    .done_weight_dma(d_weight), .done_cimeb_qkv(d_cimeb), .done_k_mode_dma(d_kmode),
    .done_loadq_dma(d_loadq), .done_q_mode_qk(d_qmode), .done_cme_softmax(d_cme),
    .down_loadscore_dma(d_score), .done_loadk_dma(d_loadk),
    .enable_cs_qkv(o_cs_qkv), .enable_cimeb_qkv(o_cimeb), .enable_cs_qk(o_cs_qk),
    .enable_k_mode_qk(o_kmode), .enable_q_mode_qk(o_qmode),
    .enable_en_softmax(o_en_sm), .enable_cme_softmax(o_cme),
    .enable_weight_dma(o_weight), .enable_loadk_dma(o_loadk),
    .enable_loadq_dma(o_loadq), .enable_loadscore_dma(o_score)
  );

  always #5 clk = ~clk;

  // Output bit masks, MSB first: cs_qkv cimeb cs_qk kmode qmode en_sm cme weight loadk loadq score
  localparam logic [10:0] CS_QKV = 11'h400, CIMEB = 11'h200, CS_QK = 11'h100;
  localparam logic [10:0] KMODE  = 11'h080, QMODE = 11'h040, EN_SM = 11'h020;
  localparam logic [10:0] CME    = 11'h010, WDMA  = 11'h008, LKDMA = 11'h004;
  localparam logic [10:0] LQDMA  = 11'h002, SCDMA = 11'h001;

  localparam logic [10:0] E_LOADW  = WDMA | CS_QKV;
  localparam logic [10:0] E_GEN    = CS_QKV | CIMEB;
  localparam logic [10:0] E_STOREK = CS_QK | KMODE | LKDMA;
  localparam logic [10:0] E_LOADQ  = CS_QK | LQDMA;
  localparam logic [10:0] E_SM     = EN_SM | CME;
  localparam logic [10:0] E_QK     = CS_QK | QMODE;
  localparam logic [10:0] E_MAC    = CS_QKV | CIMEB | EN_SM;
  localparam logic [10:0] E_STORES = SCDMA | EN_SM;

  // Done masks: weight cimeb kmode loadq qmode cme score
  localparam logic [6:0] N = 7'h00, DW = 7'h40, DC = 7'h20, DK = 7'h10;
  localparam logic [6:0] DQ = 7'h08, DQM = 7'h04, DS = 7'h02, DSC = 7'h01;

  typedef struct {
    int          cyc;
    logic [10:0] exp;
    string       name;
  } entry_t;

  entry_t sb[$];
  int cyc = 0;
  int compared = 0;
  int mismatched = 0;

  wire [10:0] outs = {o_cs_qkv, o_cimeb, o_cs_qk, o_kmode, o_qmode, o_en_sm, o_cme,
                      o_weight, o_loadk, o_loadq, o_score};

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      entry_t e;
      e = sb.pop_front();
      compared++;
      if (e.cyc < cyc) begin
        mismatched++;
        $display("FAIL %s: check missed its cycle (%0d, now %0d)", e.name, e.cyc, cyc);
      end else if (outs !== e.exp) begin
        mismatched++;
        $display("FAIL %s: enables got %b required %b", e.name, outs, e.exp);
      end
    end
  end

  task automatic push(input int c, input logic [10:0] e, input string nm);
    entry_t x;
    x.cyc = c; x.exp = e; x.name = nm;
    sb.push_back(x);
  endtask

  // Drive inputs for one edge; expected enables are those seen after that edge.
  task automatic step(input logic r, input logic [6:0] d, input logic [10:0] e,
                      input string nm);
    @(negedge clk);
    rst = r;
    {d_weight, d_cimeb, d_kmode, d_loadq, d_qmode, d_cme, d_score} = d;
    d_loadk = 1'($urandom_range(1));
    push(cyc + 1, e, nm);
    @(posedge clk);
    #1;
    {d_weight, d_cimeb, d_kmode, d_loadq, d_qmode, d_cme, d_score} = '0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) step(1'b1, N, 11'h0, "reset_hold");
    step(1'b0, N, E_LOADW, "idle_to_loadw");
    step(1'b0, DW, E_LOADW, "w1");
    step(1'b0, N, E_LOADW, "w_gap1");
    step(1'b0, DW, E_LOADW, "w2");
    step(1'b0, DS, E_LOADW, "stray_cme_in_loadw");
    step(1'b0, DW, E_LOADW, "w3_still_loadw");
    step(1'b0, N, E_LOADW, "w_gap3");
    step(1'b0, DW | DC, E_GEN, "w4_to_genk_entry_done_ignored");
    step(1'b0, N, E_GEN, "genk_hold");
    step(1'b0, DC, E_STOREK, "genk_to_storek");
    step(1'b0, DC, E_STOREK, "stray_cimeb_in_storek");
    step(1'b0, DK, E_GEN, "storek_to_genq");
    step(1'b0, DC, E_LOADQ, "genq_to_loadq");
    step(1'b0, DQ, E_QK, "first_pass_skips_softmax");
    step(1'b0, DQM, E_MAC, "qk_to_mac");
    step(1'b0, DC, E_STORES, "mac_to_stores");
    step(1'b0, DSC, E_LOADQ, "stores_to_loadq_first");
    for (int p = 0; p < 20; p++) begin
      step(1'b0, DQ, E_SM, "loop_loadq_to_softmax");
      step(1'b0, DQM, E_SM, "loop_stray_qmode_in_softmax");
      step(1'b0, DS, E_QK, "loop_softmax_to_qk");
      step(1'b0, DQM, E_MAC, "loop_qk_to_mac");
      step(1'b0, DC, E_STORES, "loop_mac_to_stores");
      step(1'b0, DSC, (p == 19) ? 11'h0 : E_LOADQ, (p == 19) ? "last_score_to_done" : "loop_stores_to_loadq");
    end
    step(1'b0, 7'h7f, 11'h0, "done_holds");
    step(1'b0, N, 11'h0, "done_holds2");

    // Second pass up to QK, then reset asynchronously mid-cycle.
    step(1'b1, N, 11'h0, "reset_after_done");
    step(1'b0, N, E_LOADW, "restart_loadw");
    for (int i = 0; i < 3; i++) step(1'b0, DW, E_LOADW, "w_back_to_back");
    step(1'b0, DW, E_GEN, "w4_again");
    step(1'b0, DC, E_STOREK, "genk_again");
    step(1'b0, DK, E_GEN, "storek_again");
    step(1'b0, DC, E_LOADQ, "genq_again");
    step(1'b0, DQ, E_QK, "first_restored_by_reset");
    @(posedge clk);
    #2;
    rst = 1'b1;
    push(cyc, 11'h0, "async_reset_in_qk");
    step(1'b1, N, 11'h0, "reset_held_after_qk");
    step(1'b0, N, E_LOADW, "restart_after_qk_reset");

    @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      mismatched += sb.size();
      $display("FAIL leftover: %0d checks never ran, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
